instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 35 +++
 rtl/fetch_queue.sv | 68 ++++++
 rtl/instr_fetch.sv | 67 ++++++
 tb/tb_instr_fetch.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Used by fetch_queue and instr_fetch.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam int PC_STEP = 4;

    localparam logic [ADDR_W-1:0]  RESET_PC_DEF = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP          = 32'h0000_0013;

    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_FULL  = 2'd2
    } q_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] align_pc(
        input logic [ADDR_W-1:0] addr
    );
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(
        input logic [ADDR_W-1:0] addr
    );
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, instr} with flush; flush beats push and pop.
// Head reads as zero while the queue is empty.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t slots [2];
    q_state_t     state;
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop & (state != Q_EMPTY);
    assign do_push = push & ((state != Q_FULL) | do_pop);
    assign count   = state;

    always_comb begin
        head = '0;
        if (state != Q_EMPTY) begin
            head = slots[rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= Q_EMPTY;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            slots[0] <= '{pc: '0, instr: NOP};
            slots[1] <= '{pc: '0, instr: NOP};
        end else if (flush) begin
            state  <= Q_EMPTY;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            // When full, wr_ptr aliases rd_ptr; that slot is being popped.
            if (do_push) begin
                slots[wr_ptr] <= push_entry;
                wr_ptr        <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case (1'b1)
                do_push & ~do_pop: begin
                    state <= (state == Q_EMPTY) ? Q_ONE : Q_FULL;
                end
                do_pop & ~do_push: begin
                    state <= (state == Q_FULL) ? Q_ONE : Q_EMPTY;
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, redirect handling and a 2-entry fetch queue.
// Memory is external; only PC and Instruction_Code cross the boundary.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter int                DEPTH    = 2
) (
    input  logic               CLK,
    input  logic               RST,
    output logic [ADDR_W-1:0]  PC,
    input  logic [INSTR_W-1:0] Instruction_Code,
    input  logic               Redirect_Valid,
    input  logic [ADDR_W-1:0]  Redirect_Target,
    output logic               Out_Valid,
    output logic [INSTR_W-1:0] Out_Instr,
    output logic [ADDR_W-1:0]  Out_PC,
    input  logic               Out_Ready,
    output logic               Misalign_Err
);

    localparam logic [1:0] DEPTH_CNT = 2'(DEPTH);

    logic [ADDR_W-1:0] pc_q;
    logic              err_q;
    logic [1:0]        q_count;
    logic              push;
    logic              pop;
    fetch_entry_t      tail_entry;
    fetch_entry_t      head_entry;

    assign Out_Valid = (q_count != 2'd0);
    // A redirecting cycle never consumes the head.
    assign pop  = Out_Valid & Out_Ready & ~Redirect_Valid;
    assign push = ~Redirect_Valid & ((q_count < DEPTH_CNT) | pop);

    assign tail_entry = '{pc: pc_q, instr: Instruction_Code};

    fetch_queue u_queue (
        .clk        (CLK),
        .rst        (RST),
        .push       (push),
        .pop        (pop),
        .flush      (Redirect_Valid),
        .push_entry (tail_entry),
        .head       (head_entry),
        .count      (q_count)
    );

    assign Out_Instr    = head_entry.instr;
    assign Out_PC       = head_entry.pc;
    assign PC           = pc_q;
    assign Misalign_Err = err_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q  <= RESET_PC;
            err_q <= 1'b0;
        end else if (Redirect_Valid) begin
            pc_q  <= align_pc(Redirect_Target);
            err_q <= err_q | is_misaligned(Redirect_Target);
        end else if (push) begin
            pc_q <= pc_q + ADDR_W'(PC_STEP);
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a queue-level reference model.
// Model tracks the fetch queue as a list of {pc, instr} entries.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        CLK;
    logic        RST;
    logic [31:0] PC;
    logic [31:0] Instruction_Code;
    logic        Redirect_Valid;
    logic [31:0] Redirect_Target;
    logic        Out_Valid;
    logic [31:0] Out_Instr;
    logic [31:0] Out_PC;
    logic        Out_Ready;
    logic        Misalign_Err;

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .PC               (PC),
        .Instruction_Code (Instruction_Code),
        .Redirect_Valid   (Redirect_Valid),
        .Redirect_Target  (Redirect_Target),
        .Out_Valid        (Out_Valid),
        .Out_Instr        (Out_Instr),
        .Out_PC           (Out_PC),
        .Out_Ready        (Out_Ready),
        .Misalign_Err     (Misalign_Err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 + {2'b00, a[31:2]};
    endfunction

    assign Instruction_Code = mem_word(PC);

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    ent_t        mq[$];
    logic [31:0] mpc  = RST_PC;
    logic        merr = 1'b0;
    bit          m_pop;
    bit          m_room;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            mq.delete();
            mpc  = RST_PC;
            merr = 1'b0;
        end else if (Redirect_Valid) begin
            mq.delete();
            if (Redirect_Target[1:0] != 2'b00) merr = 1'b1;
            mpc = Redirect_Target & 32'hFFFF_FFFC;
        end else begin
            m_pop  = (mq.size() != 0) && Out_Ready;
            m_room = (mq.size() < 2) || m_pop;
            if (m_pop) void'(mq.pop_front());
            if (m_room) begin
                mq.push_back('{pc: mpc, instr: mem_word(mpc)});
                mpc = mpc + 32'd4;
            end
        end
    end

    always @(negedge CLK) begin
        check("cmp_pc", PC, mpc);
        check("cmp_err", {31'b0, Misalign_Err}, {31'b0, merr});
        check("cmp_valid", {31'b0, Out_Valid}, {31'b0, mq.size() != 0});
        check("cmp_out_pc", Out_PC, (mq.size() != 0) ? mq[0].pc : 32'h0);
        check("cmp_out_instr", Out_Instr,
              (mq.size() != 0) ? mq[0].instr : 32'h0);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [15:0] ready_pat;

    initial begin
        RST             = 1'b1;
        Out_Ready       = 1'b1;
        Redirect_Valid  = 1'b0;
        Redirect_Target = 32'h0;
        ready_pat       = 16'b1011_0010_0111_0100;

        #10;
        check("rst_pc", PC, 32'h0);
        check("rst_valid", {31'b0, Out_Valid}, 32'h0);
        check("rst_instr", Out_Instr, 32'h0);
        check("rst_out_pc", Out_PC, 32'h0);
        check("rst_err", {31'b0, Misalign_Err}, 32'h0);
        #10;
        RST = 1'b0;

        for (int k = 0; k < 4; k++) begin
            tick();
            check("free_out_pc", Out_PC, 32'(4 * k));
            check("free_instr", Out_Instr, 32'hA000_0000 + 32'(k));
        end

        RST       = 1'b1;
        Out_Ready = 1'b0;
        tick();
        RST = 1'b0;
        repeat (5) tick();
        check("bp_pc_hold", PC, 32'h8);
        check("bp_valid", {31'b0, Out_Valid}, 32'h1);
        check("bp_head0", Out_PC, 32'h0);
        Out_Ready = 1'b1;
        tick();
        check("bp_head4", Out_PC, 32'h4);
        tick();
        check("bp_head8", Out_PC, 32'h8);

        Redirect_Valid  = 1'b1;
        Redirect_Target = 32'h40;
        tick();
        check("redir_valid", {31'b0, Out_Valid}, 32'h0);
        check("redir_pc", PC, 32'h40);
        Redirect_Valid = 1'b0;
        tick();
        check("redir_head", Out_PC, 32'h40);
        check("redir_instr", Out_Instr, 32'hA000_0010);

        Redirect_Valid  = 1'b1;
        Redirect_Target = 32'h46;
        tick();
        check("mis_pc", PC, 32'h44);
        check("mis_err", {31'b0, Misalign_Err}, 32'h1);
        Redirect_Valid = 1'b0;
        repeat (10) tick();
        check("mis_sticky", {31'b0, Misalign_Err}, 32'h1);

        Redirect_Valid  = 1'b1;
        Redirect_Target = 32'hFFFF_FFFC;
        tick();
        Redirect_Valid = 1'b0;
        tick();
        check("wrap_head0", Out_PC, 32'hFFFF_FFFC);
        check("wrap_instr0", Out_Instr, 32'hDFFF_FFFF);
        tick();
        check("wrap_head1", Out_PC, 32'h0);
        check("wrap_instr1", Out_Instr, 32'hA000_0000);

        Redirect_Valid  = 1'b1;
        Redirect_Target = 32'h100;
        tick();
        Redirect_Target = 32'h200;
        tick();
        check("dbl_pc", PC, 32'h200);
        check("dbl_valid", {31'b0, Out_Valid}, 32'h0);
        Redirect_Valid = 1'b0;
        tick();
        check("dbl_head", Out_PC, 32'h200);

        for (int i = 0; i < 16; i++) begin
            Out_Ready = ready_pat[i];
            tick();
        end
        Out_Ready = 1'b1;

        RST = 1'b1;
        #1;
        check("rst_clr_err", {31'b0, Misalign_Err}, 32'h0);
        Out_Ready = 1'b0;
        RST       = 1'b0;
        repeat (3) tick();
        check("ar_full", {31'b0, Out_Valid}, 32'h1);
        #1;
        RST = 1'b1;
        #1;
        check("ar_valid", {31'b0, Out_Valid}, 32'h0);
        check("ar_pc", PC, RST_PC);
        RST = 1'b0;
        Out_Ready = 1'b1;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
